// File: rtl/xs3_pkg.sv
// Shared constants and FSM encoding for the excess-3 to binary converter.
// The valid digit-code range and the offset are kept here so the decoder and the top agree on them.
package xs3_pkg;

   localparam logic [3:0] XS3_OFFSET = 4'd3;
   localparam logic [3:0] XS3_MIN    = 4'd3;
   localparam logic [3:0] XS3_MAX    = 4'd12;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/xs3_digit_dec.sv
// Combinational single-digit excess-3 decoder.
// An out-of-range code yields digit 0 with the invalid flag set.
module xs3_digit_dec
   import xs3_pkg::*;
(
   input  logic [3:0] code,
   output logic [3:0] digit,
   output logic       invalid
);

   assign invalid = (code < XS3_MIN) || (code > XS3_MAX);
   assign digit   = invalid ? 4'd0 : (code - XS3_OFFSET);

endmodule

// File: rtl/xs3_to_bin_seq.sv
// Digit-serial excess-3 to unsigned binary converter, most significant digit first.
// Each CONV cycle folds one digit into the accumulator as acc*10 + digit.
module xs3_to_bin_seq
   import xs3_pkg::*;
#(
   parameter int DIGITS = 4,
   parameter int OUT_W  = 14
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [4*DIGITS-1:0]   in_xs3,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [OUT_W-1:0]      out_bin,
   output logic                  out_err
);

   localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   state_t              state, state_nxt;
   logic [4*DIGITS-1:0] word_q;
   logic [CNT_W-1:0]    cnt;
   logic [OUT_W-1:0]    acc, acc_nxt;
   logic                err;
   logic [3:0]          code, digit;
   logic                invalid;

   // NOTE: sequential state is written with non-blocking assignments so every
   // register samples its inputs from before the edge, regardless of block order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // NOTE: next state is defaulted before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid)  state_nxt = CONV;
         CONV:    if (cnt == '0) state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default:                state_nxt = IDLE;
      endcase
   end

   // Digit select: shift the held word so the digit at index cnt lands in the low nibble.
   assign code = 4'(word_q >> {cnt, 2'b00});

   xs3_digit_dec u_dec (
      .code    (code),
      .digit   (digit),
      .invalid (invalid)
   );

   assign acc_nxt = (acc << 3) + (acc << 1) + OUT_W'(digit);

   // NOTE: the word register is plain flops, not a memory array, so it is
   // cleared on reset like the rest of the datapath to leave no residue.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_q <= '0;
         cnt    <= '0;
         acc    <= '0;
         err    <= 1'b0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               word_q <= in_xs3;
               cnt    <= CNT_W'(DIGITS - 1);
               acc    <= '0;
               err    <= 1'b0;
            end
            CONV: begin
               acc <= acc_nxt;
               err <= err | invalid;
               cnt <= cnt - 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign out_bin   = acc;
   assign out_err   = err;

endmodule

// File: tb/tb_xs3_to_bin_seq.sv
// Self-checking bench for xs3_to_bin_seq: directed cases, random words against a
// positional-weight model, back-pressure, mid-conversion reset, and a DIGITS=1 instance.
module tb_xs3_to_bin_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_xs3 = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [13:0] out_bin;
   logic        out_err;

   logic        in_valid1 = 1'b0;
   logic        in_ready1;
   logic [3:0]  in_xs31 = '0;
   logic        out_valid1;
   logic        out_ready1 = 1'b0;
   logic [3:0]  out_bin1;
   logic        out_err1;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   xs3_to_bin_seq #(.DIGITS(4), .OUT_W(14)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_xs3(in_xs3), .out_valid(out_valid), .out_ready(out_ready),
      .out_bin(out_bin), .out_err(out_err)
   );

   xs3_to_bin_seq #(.DIGITS(1), .OUT_W(4)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
      .in_xs3(in_xs31), .out_valid(out_valid1), .out_ready(out_ready1),
      .out_bin(out_bin1), .out_err(out_err1)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Value is the sum of each decoded digit times its decimal weight; bad codes count as 0.
   function automatic void model(input logic [15:0] w, input int ndig,
                                 output int val, output logic err);
      val = 0;
      err = 1'b0;
      for (int i = 0; i < ndig; i++) begin
         int c;
         c = int'(w[4*i +: 4]);
         if (c >= 3 && c <= 12) val += (c - 3) * (10 ** i);
         else                   err = 1'b1;
      end
   endfunction

   task automatic wait_idle();
      int t = 0;
      @(negedge clk);
      while (!in_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      check("in_ready_wait", in_ready, 1);
   endtask

   task automatic convert(input logic [15:0] w, input int stall, input string tag);
      int   edges, exp_val;
      logic exp_err;
      model(w, 4, exp_val, exp_err);
      wait_idle();
      in_xs3   = w;
      in_valid = 1'b1;
      out_ready = 1'b0;
      @(posedge clk);
      edges = 1;
      #1;
      in_valid = 1'b0;
      in_xs3   = 16'($urandom);
      check({tag, "_busy"}, in_ready, 0);
      while (!out_valid && edges < 30) begin
         @(posedge clk);
         #1;
         edges++;
      end
      check({tag, "_latency"}, edges, 5);
      check({tag, "_bin"}, out_bin, exp_val);
      check({tag, "_err"}, out_err, exp_err);
      for (int s = 0; s < stall; s++) begin
         @(negedge clk);
         check({tag, "_hold_valid"}, out_valid, 1);
         check({tag, "_hold_bin"}, out_bin, exp_val);
         check({tag, "_hold_err"}, out_err, exp_err);
         check({tag, "_hold_ready"}, in_ready, 0);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check({tag, "_release_ready"}, in_ready, 1);
      check({tag, "_release_valid"}, out_valid, 0);
   endtask

   task automatic convert1(input logic [3:0] c);
      int   edges, exp_val;
      logic exp_err;
      model({12'h0, c}, 1, exp_val, exp_err);
      @(negedge clk);
      check("d1_ready", in_ready1, 1);
      in_xs31   = c;
      in_valid1 = 1'b1;
      @(posedge clk);
      edges = 1;
      #1;
      in_valid1 = 1'b0;
      while (!out_valid1 && edges < 10) begin
         @(posedge clk);
         #1;
         edges++;
      end
      check("d1_latency", edges, 2);
      check("d1_bin", out_bin1, exp_val);
      check("d1_err", out_err1, exp_err);
      out_ready1 = 1'b1;
      @(posedge clk);
      #1;
      out_ready1 = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int q_bin[$];
      int acc_cyc[$];
      int hs_cyc[$];
      int cyc;

      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_bin", out_bin, 0);
      check("rst_out_err", out_err, 0);
      #12 rst_n = 1'b1;
      #1;
      check("rst_in_ready", in_ready, 1);

      // Directed words, including bad codes and a long back-pressure stall.
      convert(16'h4C7B, 0, "w1948");
      convert(16'h3333, 0, "w0000");
      convert(16'hCCCC, 0, "w9999");
      convert(16'h4F33, 0, "wbad_mid");
      convert(16'h2333, 0, "wbad_msd");
      convert(16'h4C7B, 6, "stall");

      // out_ready asserted early must not disturb a conversion.
      @(negedge clk);
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      check("early_ready_idle", in_ready, 1);
      out_ready = 1'b0;

      // Reset in the middle of a conversion.
      wait_idle();
      in_xs3   = 16'h4F33;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("abort_valid", out_valid, 0);
      check("abort_bin", out_bin, 0);
      check("abort_err", out_err, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("abort_ready", in_ready, 1);
      convert(16'h5A8C, 1, "after_abort");

      // Random words with a mix of legal and illegal digits.
      for (int i = 0; i < 20; i++) begin
         logic [15:0] w;
         for (int d = 0; d < 4; d++)
            w[4*d +: 4] = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(3, 12));
         convert(w, int'($urandom_range(0, 2)), "rand");
      end

      // Back-to-back words with in_valid held and out_ready high.
      wait_idle();
      in_xs3    = 16'h4C7B;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      cyc = 0;
      while (q_bin.size() < 2 && cyc < 40) begin
         if (in_valid && in_ready) acc_cyc.push_back(cyc);
         if (out_valid && out_ready) begin
            q_bin.push_back(int'(out_bin));
            hs_cyc.push_back(cyc);
         end
         @(negedge clk);
         cyc++;
         if (acc_cyc.size() == 1) in_xs3 = 16'h5A8C;
         if (acc_cyc.size() == 2) in_valid = 1'b0;
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("b2b_count", q_bin.size(), 2);
      if (q_bin.size() == 2 && acc_cyc.size() >= 2 && hs_cyc.size() >= 1) begin
         check("b2b_first", q_bin[0], 1948);
         check("b2b_second", q_bin[1], 2759);
         check("b2b_second_accept", acc_cyc[1], hs_cyc[0] + 1);
      end

      // Single-digit instance.
      convert1(4'hC);
      convert1(4'h3);
      convert1(4'h0);
      convert1(4'hF);
      convert1(4'h7);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
